spim_fifo: RTL

Parametrised SPI master for the NORA register space, successor to the single-byte SPI master used for SPI-flash access. It adds TX/RX FIFOs, a configurable number of chip-selects and a programmable SCK divider. The CPU bus decoder drives it through a two-register window: CTRL at offset 0, DATA at offset 1. Flash is on chip-select 1, the ICD/aux device on chip-select 2.

---
 rtl/spim_fifo_if.sv | 27 ++
 rtl/spim_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spim_fifo_if.sv
// spim_fifo_if: CPU register-window bus for spim_fifo.
//
// Signals:
//   reg_addr  - 0 selects CTRL, 1 selects DATA
//   reg_wr_en - one-cycle write strobe
//   reg_rd_en - one-cycle read strobe (DATA read pops the RX FIFO)
//   reg_wdata - write data
//   reg_rdata - combinational read data for the current reg_addr
//
// Modports: master (CPU bus decoder side), slave (spim_fifo side).
interface spim_fifo_if;
    logic       reg_addr;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr, reg_wr_en, reg_rd_en, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wr_en, reg_rd_en, reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/spim_fifo.sv
// spim_fifo: SPI master (mode 0) with TX/RX byte FIFOs, NUM_CS chip-selects and a
// programmable SCK divider, driven through a two-register CTRL/DATA window.
//
// Ports:
//   clk6x    - system clock
//   resetn   - asynchronous active-low reset
//   bus      - register window (spim_fifo_if.slave)
//   spi_sck  - SPI clock, idle low
//   spi_mosi - master out
//   spi_miso - master in
//   spi_csn  - active-low chip-selects, one-hot low or all high
//
// Build option: define SPIM_LSB_FIRST_EN to make CTRL[6] (lsb_first) writable and to
// build the LSB-first shift path. Without it CTRL[6] reads 0 and transfers are MSB-first.
module spim_fifo #(
    parameter int unsigned NUM_CS  = 2,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic              clk6x,
    input  logic              resetn,
    spim_fifo_if.slave        bus,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_csn
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;  // last SCK high phase before the final fall

    localparam logic [FIFO_AW:0] PtrOne = (FIFO_AW + 1)'(1);

    logic ctrl_wr, data_wr, ctrl_rd, data_rd, flush;
    assign ctrl_wr = bus.reg_wr_en & ~bus.reg_addr;
    assign data_wr = bus.reg_wr_en &  bus.reg_addr;
    assign ctrl_rd = bus.reg_rd_en & ~bus.reg_addr;
    assign data_rd = bus.reg_rd_en &  bus.reg_addr;
    assign flush   = ctrl_wr & bus.reg_wdata[7];

    // Control registers
    logic [2:0] cs_sel_q, speed_q;
    logic       rx_ovf_q;
    logic       lsb_first;

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            cs_sel_q <= 3'd0;
            speed_q  <= 3'd7;
        end else if (ctrl_wr) begin
            cs_sel_q <= bus.reg_wdata[2:0];
            speed_q  <= bus.reg_wdata[5:3];
        end
    end

    // FIFOs: pointers carry one extra bit to tell full from empty
    logic [FIFO_AW:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [7:0]       tx_mem [1 << FIFO_AW];
    logic [7:0]       rx_mem [1 << FIFO_AW];
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic             tx_push, tx_pop, rx_push, rx_pop, rx_push_ok, ovf_set;
    logic [7:0]       tx_head, rx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign tx_full  = (tx_wptr_q == {~tx_rptr_q[FIFO_AW], tx_rptr_q[FIFO_AW-1:0]});
    assign rx_full  = (rx_wptr_q == {~rx_rptr_q[FIFO_AW], rx_rptr_q[FIFO_AW-1:0]});
    assign tx_head  = tx_mem[tx_rptr_q[FIFO_AW-1:0]];
    assign rx_head  = rx_mem[rx_rptr_q[FIFO_AW-1:0]];

    // A push into a full FIFO is still honoured when a pop frees a slot the same cycle
    assign tx_push    = data_wr & (~tx_full | tx_pop);
    assign rx_pop     = data_rd & ~rx_empty;
    assign rx_push_ok = rx_push & (~rx_full | rx_pop);
    assign ovf_set    = rx_push & rx_full & ~rx_pop;

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else if (flush) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (tx_push)    tx_wptr_q <= tx_wptr_q + PtrOne;
            if (tx_pop)     tx_rptr_q <= tx_rptr_q + PtrOne;
            if (rx_push_ok) rx_wptr_q <= rx_wptr_q + PtrOne;
            if (rx_pop)     rx_rptr_q <= rx_rptr_q + PtrOne;
        end
    end

    logic [7:0] rx_sh_q;

    always_ff @(posedge clk6x) begin
        if (tx_push)    tx_mem[tx_wptr_q[FIFO_AW-1:0]] <= bus.reg_wdata;
        if (rx_push_ok) rx_mem[rx_wptr_q[FIFO_AW-1:0]] <= rx_sh_q;
    end

    // Sticky overflow; a set wins over a same-cycle CTRL read clear
    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) rx_ovf_q <= 1'b0;
        else         rx_ovf_q <= ovf_set | (rx_ovf_q & ~ctrl_rd);
    end

    // Shift path
    logic [7:0] tx_sh_q, tx_sh_next, rx_sh_next;
    logic       first_bit, next_bit;

`ifdef SPIM_LSB_FIRST_EN
    logic lsb_first_q;

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn)      lsb_first_q <= 1'b0;
        else if (ctrl_wr) lsb_first_q <= bus.reg_wdata[6];
    end

    assign lsb_first  = lsb_first_q;
    assign first_bit  = lsb_first_q ? tx_head[0] : tx_head[7];
    assign next_bit   = lsb_first_q ? tx_sh_q[1] : tx_sh_q[6];
    assign tx_sh_next = lsb_first_q ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
    assign rx_sh_next = lsb_first_q ? {spi_miso, rx_sh_q[7:1]} : {rx_sh_q[6:0], spi_miso};
`else
    logic unused_lsb;
    assign unused_lsb = bus.reg_wdata[6] ^ tx_sh_q[7];

    assign lsb_first  = 1'b0;
    assign first_bit  = tx_head[7];
    assign next_bit   = tx_sh_q[6];
    assign tx_sh_next = {tx_sh_q[6:0], 1'b0};
    assign rx_sh_next = {rx_sh_q[6:0], spi_miso};
`endif

    // Engine
    logic [1:0]        state_q, state_d;
    logic              sck_q, sck_d, mosi_q, mosi_d;
    logic [NUM_CS-1:0] csn_q, csn_d, csn_dec;
    logic [6:0]        div_q, div_d, half_m1;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        tx_sh_d, rx_sh_d;
    logic              cs_valid, half_done, busy;

    assign half_m1   = 7'((8'd1 << speed_q) - 8'd1);
    assign half_done = (div_q == half_m1);
    assign cs_valid  = (cs_sel_q != 3'd0) && (32'(cs_sel_q) <= NUM_CS);
    assign busy      = (state_q != StIdle) | ~tx_empty;

    always_comb begin
        csn_dec = '1;
        for (int unsigned k = 0; k < NUM_CS; k++) begin
            if (32'(cs_sel_q) == k + 1) csn_dec[k] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        // chip-selects only follow cs_sel between bytes
        csn_d     = (state_q == StIdle) ? csn_dec : csn_q;
        if (flush) begin
            state_d = StIdle;
            sck_d   = 1'b0;
            div_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!tx_empty && cs_valid) begin
                        tx_pop    = 1'b1;
                        tx_sh_d   = tx_head;
                        mosi_d    = first_bit;
                        div_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = StShift;
                    end
                end
                StShift: begin
                    if (half_done) begin
                        div_d = '0;
                        sck_d = ~sck_q;
                        if (!sck_q) begin
                            rx_sh_d   = rx_sh_next;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_d = StDone;
                        end else begin
                            tx_sh_d = tx_sh_next;
                            mosi_d  = next_bit;
                        end
                    end else begin
                        div_d = div_q + 7'd1;
                    end
                end
                StDone: begin
                    if (half_done) begin
                        div_d   = '0;
                        sck_d   = 1'b0;
                        rx_push = 1'b1;
                        state_d = StIdle;
                    end else begin
                        div_d = div_q + 7'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            csn_q     <= '1;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
        end else begin
            state_q   <= state_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            csn_q     <= csn_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
        end
    end

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_csn  = csn_q;

    assign bus.reg_rdata = bus.reg_addr ? (rx_empty ? 8'hFF : rx_head)
                                        : {rx_ovf_q, lsb_first, rx_empty, tx_full, busy, cs_sel_q};
endmodule
